// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM/special-case encodings, format constants and operand classifiers
package fp_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ITER, NORM, ROUND} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

    function automatic int bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set
    function automatic logic [127:0] qnan(input int ew, input int mw);
        return (((128'd1 << ew) - 128'd1) << mw) | (128'd1 << (mw - 1));
    endfunction

    // Denormals (exp=0) count as zero
    function automatic logic is_zero(input logic [31:0] e);
        return e == 32'd0;
    endfunction

    function automatic logic is_inf(input logic [31:0] e, input logic [127:0] f, input int ew);
        return e == ((32'd1 << ew) - 32'd1) && f == '0;
    endfunction

    function automatic logic is_nan(input logic [31:0] e, input logic [127:0] f, input int ew);
        return e == ((32'd1 << ew) - 32'd1) && f != '0;
    endfunction

endpackage

// File: rtl/man_div_iter.sv
// man_div_iter: restoring mantissa divider producing one quotient bit per step
module man_div_iter #(
    parameter int N  = 24,
    parameter int QW = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic [QW-1:0] q,
    output logic          sticky
);
    logic [N:0]   rem;
    logic [N-1:0] d;
    logic [N:0]   diff;
    logic         ge;

    assign diff   = rem - {1'b0, d};
    assign ge     = rem >= {1'b0, d};
    assign sticky = |rem;

    // Partial remainder stays below the divisor, so its top bit is always clear before the shift
    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            d   <= '0;
            q   <= '0;
        end else if (load) begin
            rem <= {1'b0, a};
            d   <= b;
            q   <= '0;
        end else if (step) begin
            rem <= {ge ? diff[N-1:0] : rem[N-1:0], 1'b0};
            q   <= {q[QW-2:0], ge};
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 divider, fixed MAN_W+6 cycle latency, RNE, flush-to-zero
module fp_div_seq import fp_pkg::*; #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [EXP_W+MAN_W:0]     dnd,
    input  logic [EXP_W+MAN_W:0]     der,
    output logic                     busy,
    output logic                     done,
    output logic [EXP_W+MAN_W:0]     quo,
    output logic                     ovf,
    output logic                     unf,
    output logic                     dz,
    output logic                     inv
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int QW = MAN_W + 3;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(QW + 1);
    localparam logic [W-1:0]          QNAN   = W'(qnan(EXP_W, MAN_W));
    localparam logic signed [XW-1:0]  BIAS_X = XW'(bias(EXP_W));
    localparam logic signed [XW-1:0]  EMAX_X = XW'((1 << EXP_W) - 1);

    state_t                  state;
    spec_t                   sp, sp_n;
    logic [W-1:0]            a_r, b_r;
    logic                    sgn, sp_dz, dz_n, nan_n;
    logic signed [XW-1:0]    e, e_n, e_r;
    logic [QW-1:0]           mq, q;
    logic [CW-1:0]           cnt;
    logic                    stk, za, zb, ia, ib, na, nb, rup, ovf_c, unf_c;
    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        fa, fb;
    logic [MAN_W+1:0]        mant;
    logic [W-1:0]            res;

    assign ea = a_r[W-2:MAN_W];
    assign eb = b_r[W-2:MAN_W];
    assign fa = a_r[MAN_W-1:0];
    assign fb = b_r[MAN_W-1:0];
    assign za = is_zero(32'(ea));
    assign zb = is_zero(32'(eb));
    assign ia = is_inf(32'(ea), 128'(fa), EXP_W);
    assign ib = is_inf(32'(eb), 128'(fb), EXP_W);
    assign na = is_nan(32'(ea), 128'(fa), EXP_W);
    assign nb = is_nan(32'(eb), 128'(fb), EXP_W);

    // Special-case priority: invalid, divide-by-zero / inf numerator, zero result
    assign nan_n = na | nb | (za & zb) | (ia & ib);
    assign sp_n  = nan_n ? SP_NAN : (ia | zb) ? SP_INF : (za | ib) ? SP_ZERO : SP_NONE;
    assign dz_n  = !nan_n & zb & !ia;
    assign e_n   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_X;

    man_div_iter #(.N(MAN_W + 1), .QW(QW)) u_div (
        .clk    (clk),
        .rst    (rst),
        .load   (state == LOAD),
        .step   (state == ITER),
        .a      ({1'b1, fa}),
        .b      ({1'b1, fb}),
        .q      (q),
        .sticky (stk)
    );

    // mq holds {1, frac, guard, round}; sticky comes straight from the divider remainder
    always_comb begin
        rup   = mq[1] & (mq[0] | stk | mq[2]);
        mant  = {2'b01, mq[QW-2:2]} + {{(MAN_W+1){1'b0}}, rup};
        e_r   = e + $signed({{(XW-1){1'b0}}, mant[MAN_W+1]});
        ovf_c = !e_r[XW-1] && e_r >= EMAX_X;
        unf_c = e_r[XW-1] || e_r == '0;
        res   = sp == SP_NAN ? QNAN :
                (sp == SP_INF || (sp == SP_NONE && ovf_c)) ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                (sp == SP_ZERO || unf_c) ? {sgn, {(W-1){1'b0}}} :
                {sgn, e_r[EXP_W-1:0], mant[MAN_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            quo   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            dz    <= 1'b0;
            inv   <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sgn   <= 1'b0;
            e     <= '0;
            sp    <= SP_NONE;
            sp_dz <= 1'b0;
            mq    <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_r   <= dnd;
                    b_r   <= der;
                    busy  <= 1'b1;
                    ovf   <= 1'b0;
                    unf   <= 1'b0;
                    dz    <= 1'b0;
                    inv   <= 1'b0;
                    state <= LOAD;
                end
                LOAD: begin
                    sgn   <= a_r[W-1] ^ b_r[W-1];
                    e     <= e_n;
                    sp    <= sp_n;
                    sp_dz <= dz_n;
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    cnt   <= cnt + 1'b1;
                    state <= cnt == CW'(QW - 1) ? NORM : ITER;
                end
                NORM: begin
                    mq    <= q[QW-1] ? q : {q[QW-2:0], 1'b0};
                    e     <= q[QW-1] ? e : e - XW'(1);
                    state <= ROUND;
                end
                ROUND: begin
                    quo   <= res;
                    inv   <= sp == SP_NAN;
                    dz    <= sp == SP_INF && sp_dz;
                    ovf   <= sp == SP_NONE && ovf_c;
                    unf   <= sp == SP_NONE && unf_c;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed checks of single- and double-precision sequential division
module tb_fp_div_seq;
    logic        clk = 1'b0;
    logic        rst, start, start_d;
    logic [31:0] dnd, der, quo;
    logic [63:0] dnd_d, der_d, quo_d;
    logic        busy, done, ovf, unf, dz, inv;
    logic        busy_d, done_d, ovf_d, unf_d, dz_d, inv_d;
    int          nvec = 0;
    int          nerr = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [3:0]  f;
    } vec_t;

    always #5 clk = ~clk;

    fp_div_seq u_sp (
        .clk(clk), .rst(rst), .start(start), .dnd(dnd), .der(der),
        .busy(busy), .done(done), .quo(quo), .ovf(ovf), .unf(unf), .dz(dz), .inv(inv)
    );

    fp_div_seq #(.EXP_W(11), .MAN_W(52)) u_dp (
        .clk(clk), .rst(rst), .start(start_d), .dnd(dnd_d), .der(der_d),
        .busy(busy_d), .done(done_d), .quo(quo_d), .ovf(ovf_d), .unf(unf_d), .dz(dz_d), .inv(inv_d)
    );

    task automatic op_sp(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [3:0] fl, output int lat);
        @(negedge clk);
        dnd = a; der = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            @(negedge clk);
            if (done) lat = n;
        end
        q  = quo;
        fl = {ovf, unf, dz, inv};
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start_d = 1'b0;
        dnd = '0; der = '0; dnd_d = '0; der_d = '0;
        repeat (2) @(negedge clk);
        nvec++;
        if ({busy, done, ovf, unf, dz, inv} !== 6'b0) begin
            nerr++; $display("FAIL reset_ctl got %b want 000000", {busy, done, ovf, unf, dz, inv});
        end
        nvec++;
        if (quo !== 32'h0) begin nerr++; $display("FAIL reset_quo got %h want 0", quo); end
        nvec++;
        if ({busy_d, done_d, quo_d} !== 66'b0) begin
            nerr++; $display("FAIL reset_dp got busy=%b done=%b quo=%h want zeros", busy_d, done_d, quo_d);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors;
        vec_t        tv [13];
        logic [31:0] q;
        logic [3:0]  fl;
        int          lat;
        tv[0]  = {32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000};
        tv[1]  = {32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000};
        tv[2]  = {32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 4'b0000};
        tv[3]  = {32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010};
        tv[4]  = {32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0010};
        tv[5]  = {32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001};
        tv[6]  = {32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0001};
        tv[7]  = {32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001};
        tv[8]  = {32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000};
        tv[9]  = {32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000};
        tv[10] = {32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b1000};
        tv[11] = {32'h00800000, 32'h40000000, 32'h00000000, 4'b0100};
        tv[12] = {32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 4'b0000};
        for (int i = 0; i < 13; i++) begin
            op_sp(tv[i].a, tv[i].b, q, fl, lat);
            nvec++;
            if (lat !== 29) begin nerr++; $display("FAIL vec%0d_latency got %0d want 29", i, lat); end
            nvec++;
            if (q !== tv[i].q) begin nerr++; $display("FAIL vec%0d_quo got %h want %h", i, q, tv[i].q); end
            nvec++;
            if (fl !== tv[i].f) begin nerr++; $display("FAIL vec%0d_flags got %b want %b", i, fl, tv[i].f); end
        end
    endtask

    task automatic test_ignore_start;
        int dones = 0;
        int first = -1;
        @(negedge clk);
        dnd = 32'h40C00000; der = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nvec++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL busy_after_accept got %b want 1", busy); end
        for (int n = 1; n <= 40; n++) begin
            start = (n == 5 || n == 10);
            if (start) begin dnd = 32'h3F800000; der = 32'h40400000; end
            @(negedge clk);
            if (done) begin dones++; if (first < 0) first = n; end
        end
        start = 1'b0;
        nvec++;
        if (dones !== 1) begin nerr++; $display("FAIL ignore_dones got %0d want 1", dones); end
        nvec++;
        if (first !== 29) begin nerr++; $display("FAIL ignore_latency got %0d want 29", first); end
        nvec++;
        if (quo !== 32'h40400000) begin nerr++; $display("FAIL ignore_quo got %h want 40400000", quo); end
    endtask

    task automatic test_reset_abort;
        int dones = 0;
        @(negedge clk);
        dnd = 32'h3F800000; der = 32'h00000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if ({busy, done, ovf, unf, dz, inv} !== 6'b0) begin
            nerr++; $display("FAIL abort_ctl got %b want 000000", {busy, done, ovf, unf, dz, inv});
        end
        nvec++;
        if (quo !== 32'h0) begin nerr++; $display("FAIL abort_quo got %h want 0", quo); end
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        nvec++;
        if (dones !== 0) begin nerr++; $display("FAIL abort_dones got %0d want 0", dones); end
        rst = 1'b1; start = 1'b1; dnd = 32'h40C00000; der = 32'h40000000;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        nvec++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL rst_start_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat = -1;
        @(negedge clk);
        dnd = 32'h3F800000; der = 32'h00000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            @(negedge clk);
            if (done) lat = n;
        end
        nvec++;
        if ({lat == 29, busy, dz} !== 3'b101) begin
            nerr++; $display("FAIL b2b_first got lat=%0d busy=%b dz=%b want lat=29 busy=0 dz=1", lat, busy, dz);
        end
        dnd = 32'h40C00000; der = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nvec++;
        if ({busy, done, dz} !== 3'b100) begin
            nerr++; $display("FAIL b2b_accept got busy=%b done=%b dz=%b want 1 0 0", busy, done, dz);
        end
        lat = -1;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            @(negedge clk);
            if (done) lat = n;
        end
        nvec++;
        if (lat !== 29) begin nerr++; $display("FAIL b2b_latency got %0d want 29", lat); end
        nvec++;
        if ({quo, ovf, unf, dz, inv} !== {32'h40400000, 4'b0000}) begin
            nerr++; $display("FAIL b2b_result got %h/%b want 40400000/0000", quo, {ovf, unf, dz, inv});
        end
    endtask

    task automatic test_double;
        logic [63:0] va [2];
        logic [63:0] vb [2];
        logic [63:0] vq [2];
        va[0] = 64'h4018000000000000; vb[0] = 64'h4000000000000000; vq[0] = 64'h4008000000000000;
        va[1] = 64'h3FF0000000000000; vb[1] = 64'h4008000000000000; vq[1] = 64'h3FD5555555555555;
        for (int i = 0; i < 2; i++) begin
            int lat = -1;
            @(negedge clk);
            dnd_d = va[i]; der_d = vb[i]; start_d = 1'b1;
            @(negedge clk);
            start_d = 1'b0;
            for (int n = 1; n <= 150 && lat < 0; n++) begin
                @(negedge clk);
                if (done_d) lat = n;
            end
            nvec++;
            if (lat !== 58) begin nerr++; $display("FAIL dp%0d_latency got %0d want 58", i, lat); end
            nvec++;
            if (quo_d !== vq[i]) begin nerr++; $display("FAIL dp%0d_quo got %h want %h", i, quo_d, vq[i]); end
            nvec++;
            if ({ovf_d, unf_d, dz_d, inv_d} !== 4'b0000) begin
                nerr++; $display("FAIL dp%0d_flags got %b want 0000", i, {ovf_d, unf_d, dz_d, inv_d});
            end
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_ignore_start;
        test_reset_abort;
        test_back_to_back;
        test_double;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
